// File: rtl/led_to_bcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : led_to_bcd_capture
// Purpose  : Reads back a multiplexed active-low 7-segment display bus.
//            It waits for a stable one-hot digit sample, decodes the
//            segments to BCD, stores one nibble per digit, and flags
//            illegal patterns and completed frames.
// Revision : 1.0 - initial release
// ============================================================================
module led_to_bcd_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter bit DIG_ACT_LOW   = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [6:0]                               seg,
  input  logic [NUM_DIGITS-1:0]                    dig_en,
  output logic [4*NUM_DIGITS-1:0]                  bcd_out,
  output logic [NUM_DIGITS-1:0]                    digit_valid,
  output logic                                     frame_valid,
  output logic                                     err,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] err_digit
);

  localparam int C_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int C_CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT  = C_CNT_W'(STABLE_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DWELL    = 2'd1,
    S_CAPTURED = 2'd2
  } state_t;

  state_t                  r_state, w_nxt_state;
  logic [6:0]              r_seg, r_hold_seg, w_nxt_hold_seg;
  logic [NUM_DIGITS-1:0]   r_en, r_hold_en, w_nxt_hold_en;
  logic [C_CNT_W-1:0]      r_cnt, w_nxt_cnt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   w_seen_upd;
  logic                    w_onehot;
  logic                    w_same;
  logic                    w_capture;
  logic [C_IDX_W-1:0]      w_idx;
  logic                    w_legal;
  logic                    w_blank;
  logic [3:0]              w_val;

  // Raw active-low segment pattern to {legal, digit}.
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'h40:   f_decode = 5'h10;
      7'h79:   f_decode = 5'h11;
      7'h24:   f_decode = 5'h12;
      7'h30:   f_decode = 5'h13;
      7'h19:   f_decode = 5'h14;
      7'h12:   f_decode = 5'h15;
      7'h02:   f_decode = 5'h16;
      7'h78:   f_decode = 5'h17;
      7'h00:   f_decode = 5'h18;
      7'h10:   f_decode = 5'h19;
      default: f_decode = 5'h00;
    endcase
  endfunction

  assign w_onehot = $onehot(r_en);
  assign w_same   = (r_seg == r_hold_seg) && (r_en == r_hold_en);
  assign {w_legal, w_val} = f_decode(r_seg);
  assign w_blank  = (r_seg == 7'h7F);
  assign w_seen_upd = r_seen | r_en;

  // Position of the active digit; only meaningful when the enable is one-hot.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_en[i]) w_idx = C_IDX_W'(i);
    end
  end

  // Register the bus once, with enables normalised to active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= '0;
      r_en  <= '0;
    end else begin
      r_seg <= seg;
      r_en  <= DIG_ACT_LOW ? ~dig_en : dig_en;
    end
  end

  // FSM state, dwell counter and the sample being dwelled on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hold_seg <= '0;
      r_hold_en  <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_hold_seg <= w_nxt_hold_seg;
      r_hold_en  <= w_nxt_hold_en;
    end
  end

  // Next-state logic: restart the dwell on any change, capture once per dwell.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_cnt;
    w_nxt_hold_seg = r_hold_seg;
    w_nxt_hold_en  = r_hold_en;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = '0;
        if (w_onehot) begin
          w_nxt_state    = S_DWELL;
          w_nxt_cnt      = C_CNT_ONE;
          w_nxt_hold_seg = r_seg;
          w_nxt_hold_en  = r_en;
        end
      end
      S_DWELL: begin
        if (w_same) begin
          if (r_cnt >= C_CNT_LAST) begin
            w_capture   = 1'b1;
            w_nxt_state = S_CAPTURED;
            w_nxt_cnt   = C_CNT_SAT;
          end else begin
            w_nxt_cnt = r_cnt + C_CNT_ONE;
          end
        end else if (w_onehot) begin
          w_nxt_cnt      = C_CNT_ONE;
          w_nxt_hold_seg = r_seg;
          w_nxt_hold_en  = r_en;
        end else begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end
      end
      S_CAPTURED: begin
        if (!w_same) begin
          if (w_onehot) begin
            w_nxt_state    = S_DWELL;
            w_nxt_cnt      = C_CNT_ONE;
            w_nxt_hold_seg = r_seg;
            w_nxt_hold_en  = r_en;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
          end
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Capture datapath: nibble store, validity, error and frame tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out     <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_digit   <= '0;
      r_seen      <= '0;
    end else begin
      err         <= 1'b0;
      frame_valid <= 1'b0;
      if (w_capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (r_en[i]) begin
            if (w_legal) begin
              bcd_out[4*i +: 4] <= w_val;
              digit_valid[i]    <= 1'b1;
            end else if (w_blank) begin
              bcd_out[4*i +: 4] <= 4'hF;
              digit_valid[i]    <= 1'b0;
            end else begin
              digit_valid[i]    <= 1'b0;
            end
          end
        end
        if (!w_legal && !w_blank) begin
          err       <= 1'b1;
          err_digit <= w_idx;
        end
        if (&w_seen_upd) begin
          frame_valid <= 1'b1;
          r_seen      <= '0;
        end else begin
          r_seen      <= w_seen_upd;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_to_bcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_to_bcd_capture
// Purpose  : Self-checking bench for led_to_bcd_capture: directed scenarios
//            plus randomized bus traffic against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_to_bcd_capture;

  localparam int N  = 8;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg;
  logic [N-1:0]  dig_en;
  logic [4*N-1:0] bcd_out;
  logic [N-1:0]  digit_valid;
  logic          frame_valid;
  logic          err;
  logic [2:0]    err_digit;

  led_to_bcd_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC), .DIG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_valid(frame_valid),
    .err(err), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Segment patterns for digits 0..9 on the raw active-low bus.
  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state.
  logic [3:0]   m_bcd [N];
  logic [N-1:0] m_dv, m_seen;
  logic         m_err, m_fv;
  logic [2:0]   m_ed;
  logic [6:0]   p_seg, l_seg;   // sample in the input register / previous one
  logic [N-1:0] p_en,  l_en;
  int           run;            // length of the current run of identical samples

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (pat[k] == s) return k;
    if (s == 7'h7F) return 15;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_bcd[i] = 4'h0;
    m_dv = '0; m_seen = '0; m_err = 1'b0; m_fv = 1'b0; m_ed = '0;
    p_seg = '0; p_en = '0; l_seg = '0; l_en = '0; run = 0;
  endtask

  // One clock edge: the run of identical registered samples reaching
  // exactly SC with a single enabled digit yields one capture.
  task automatic model_edge(input logic [6:0] s, input logic [N-1:0] d);
    int idx, v;
    m_err = 1'b0;
    m_fv  = 1'b0;
    if (p_seg == l_seg && p_en == l_en) run = (run < 1000) ? run + 1 : run;
    else run = 1;
    l_seg = p_seg; l_en = p_en;
    if (run == SC && $countones(p_en) == 1) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (p_en[i]) idx = i;
      v = decode(p_seg);
      if (v >= 0 && v <= 9) begin
        m_bcd[idx] = v[3:0]; m_dv[idx] = 1'b1;
      end else if (v == 15) begin
        m_bcd[idx] = 4'hF; m_dv[idx] = 1'b0;
      end else begin
        m_dv[idx] = 1'b0; m_err = 1'b1; m_ed = idx[2:0];
      end
      m_seen = m_seen | p_en;
      if (&m_seen) begin
        m_fv = 1'b1; m_seen = '0;
      end
    end
    p_seg = s;
    p_en  = ~d;
  endtask

  task automatic compare_all();
    logic [4*N-1:0] exp_bcd;
    for (int i = 0; i < N; i++) exp_bcd[4*i +: 4] = m_bcd[i];
    check("bcd_out", 64'(bcd_out), 64'(exp_bcd));
    check("digit_valid", 64'(digit_valid), 64'(m_dv));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("err", 64'(err), 64'(m_err));
    check("err_digit", 64'(err_digit), 64'(m_ed));
  endtask

  task automatic cyc(input logic [6:0] s, input logic [N-1:0] d);
    seg = s; dig_en = d;
    @(posedge clk);
    model_edge(s, d);
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] en_of(input int d);
    logic [N-1:0] one;
    one = 1;
    return ~(one << d);
  endfunction

  initial begin
    int fcount, ecount, saw_ed;
    rst = 1'b1; seg = 7'h7F; dig_en = '1;
    model_reset();
    #3;
    compare_all();
    @(posedge clk);
    #2 rst = 1'b0;

    // Latency: capture lands on the fourth edge after the first sample edge.
    for (int k = 0; k < 5; k++) begin
      cyc(7'h24, 8'hFE);
      if (k == 3) check("lat_e3_dv", 64'(digit_valid[0]), 64'd0);
      if (k == 4) begin
        check("lat_e4_dv", 64'(digit_valid[0]), 64'd1);
        check("lat_e4_nib", 64'(bcd_out[3:0]), 64'd2);
      end
    end

    // Reset in the middle of a dwell discards it.
    cyc(7'h12, 8'hFE);
    cyc(7'h12, 8'hFE);
    do_reset();
    check("rst_bcd", 64'(bcd_out), 64'd0);
    for (int k = 0; k < 3; k++) cyc(7'h12, 8'hFE);
    check("rst_nocap", 64'(digit_valid[0]), 64'd0);
    for (int k = 0; k < 2; k++) cyc(7'h12, 8'hFE);
    check("rst_recap", 64'(bcd_out[3:0]), 64'd5);

    // Glitch: a short run of 3 must not capture.
    for (int k = 0; k < 3; k++) cyc(7'h30, en_of(1));
    for (int k = 0; k < 5; k++) cyc(7'h19, en_of(1));
    check("glitch_nib", 64'(bcd_out[7:4]), 64'd4);

    // Illegal pattern then blank on digit 3.
    for (int k = 0; k < 5; k++) cyc(7'h24, en_of(3));
    ecount = 0; saw_ed = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(7'h7E, en_of(3));
      if (err) begin ecount++; saw_ed = int'(err_digit); end
    end
    check("ill_err_cnt", 64'(ecount), 64'd1);
    check("ill_err_digit", 64'(saw_ed), 64'd3);
    check("ill_nib_kept", 64'(bcd_out[15:12]), 64'd2);
    ecount = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(7'h7F, en_of(3));
      if (err) ecount++;
    end
    check("blank_nib", 64'(bcd_out[15:12]), 64'hF);
    check("blank_dv", 64'(digit_valid[3]), 64'd0);
    check("blank_noerr", 64'(ecount), 64'd0);

    // Full frame scan.
    do_reset();
    fcount = 0;
    for (int d = 0; d < N; d++) begin
      for (int k = 0; k < 6; k++) begin
        cyc(pat[d], en_of(d));
        if (frame_valid) fcount++;
      end
    end
    check("frame_count", 64'(fcount), 64'd1);
    check("frame_bcd", 64'(bcd_out), 64'h76543210);

    // Bad enables: two digits, then none.
    ecount = 0;
    for (int k = 0; k < 20; k++) begin cyc(pat[3], 8'hFC); if (err) ecount++; end
    for (int k = 0; k < 20; k++) begin cyc(7'h7E, 8'hFF); if (err) ecount++; end
    check("bad_en_err", 64'(ecount), 64'd0);
    check("bad_en_bcd", 64'(bcd_out), 64'h76543210);
    check("bad_en_dv", 64'(digit_valid), 64'hFF);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int d, r, hold;
      logic [6:0]   s;
      logic [N-1:0] e;
      d = $urandom_range(0, N - 1);
      r = $urandom_range(0, 99);
      e = en_of(d);
      if (r < 70)      s = pat[$urandom_range(0, 9)];
      else if (r < 80) s = 7'h7F;
      else if (r < 90) s = 7'($urandom);
      else begin
        s = pat[$urandom_range(0, 9)];
        e = N'($urandom);
      end
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) cyc(s, e);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
